// File: rtl/prefix_pkg.sv
// Shared constants, encodings and helpers for the x86 prefix scanner.
package prefix_pkg;

  localparam logic [7:0] PFX_ES     = 8'h26;
  localparam logic [7:0] PFX_CS     = 8'h2E;
  localparam logic [7:0] PFX_SS     = 8'h36;
  localparam logic [7:0] PFX_DS     = 8'h3E;
  localparam logic [7:0] PFX_FS     = 8'h64;
  localparam logic [7:0] PFX_GS     = 8'h65;
  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] PFX_LOCK   = 8'hF0;
  localparam logic [7:0] PFX_REPNE  = 8'hF2;
  localparam logic [7:0] PFX_REP    = 8'hF3;

  typedef enum logic [2:0] {
    SEG_ES = 3'd0,
    SEG_CS = 3'd1,
    SEG_SS = 3'd2,
    SEG_DS = 3'd3,
    SEG_FS = 3'd4,
    SEG_GS = 3'd5
  } seg_e;

  typedef enum logic [1:0] {
    REP_NONE = 2'b00,
    REP_NE   = 2'b10,
    REP_E    = 2'b11
  } rep_e;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int unsigned LEN_W = 4;
  localparam logic [LEN_W-1:0] LEN_MAX = 4'hF;

  // Width needed to hold a byte count of 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/prefix_byte_classify.sv
// Decodes one instruction byte into its prefix class and payload.
module prefix_byte_classify
  import prefix_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic       is_prefix,
  output logic       is_seg,
  output logic [2:0] seg,
  output logic       is_opsize,
  output logic       is_lock,
  output logic       is_rep,
  output logic [1:0] rep
);

  always_comb begin
    is_seg    = 1'b0;
    seg       = SEG_ES;
    is_opsize = 1'b0;
    is_lock   = 1'b0;
    is_rep    = 1'b0;
    rep       = REP_NONE;
    case (in_byte)
      PFX_ES:     begin is_seg = 1'b1; seg = SEG_ES; end
      PFX_CS:     begin is_seg = 1'b1; seg = SEG_CS; end
      PFX_SS:     begin is_seg = 1'b1; seg = SEG_SS; end
      PFX_DS:     begin is_seg = 1'b1; seg = SEG_DS; end
      PFX_FS:     begin is_seg = 1'b1; seg = SEG_FS; end
      PFX_GS:     begin is_seg = 1'b1; seg = SEG_GS; end
      PFX_OPSIZE: is_opsize = 1'b1;
      PFX_LOCK:   is_lock = 1'b1;
      PFX_REPNE:  begin is_rep = 1'b1; rep = REP_NE; end
      PFX_REP:    begin is_rep = 1'b1; rep = REP_E; end
      default:    ;
    endcase
    is_prefix = is_seg | is_opsize | is_lock | is_rep;
  end

endmodule

// File: rtl/prefix_scan_unit.sv
// Windowed prefix scanner: accumulates leading prefix bytes across windows
// and hands one registered prefix record per instruction downstream.
module prefix_scan_unit
  import prefix_pkg::*;
#(
  parameter int unsigned W          = 3,
  parameter int unsigned MAX_PREFIX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [8*W-1:0]            in_bytes,
  output logic                      in_ready,
  output logic [cnt_width(W)-1:0]   in_consume,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_seg_valid,
  output logic [2:0]                out_seg,
  output logic                      out_opsize,
  output logic                      out_lock,
  output logic [1:0]                out_rep,
  output logic [3:0]                out_len,
  output logic                      out_err
);

  localparam int unsigned CW    = cnt_width(W);
  localparam int unsigned SUM_W = LEN_W + 1;

  logic [W-1:0] lane_prefix, lane_is_seg, lane_opsize, lane_lock, lane_is_rep;
  logic [2:0]   lane_seg [W];
  logic [1:0]   lane_rep [W];

  for (genvar g = 0; g < W; g++) begin : g_lane
    prefix_byte_classify u_cls (
      .in_byte   (in_bytes[8*g +: 8]),
      .is_prefix (lane_prefix[g]),
      .is_seg    (lane_is_seg[g]),
      .seg       (lane_seg[g]),
      .is_opsize (lane_opsize[g]),
      .is_lock   (lane_lock[g]),
      .is_rep    (lane_is_rep[g]),
      .rep       (lane_rep[g])
    );
  end

  state_e           state_q;
  logic             valid_q, seg_valid_q, opsize_q, lock_q, err_q;
  logic [2:0]       seg_q;
  logic [1:0]       rep_q;
  logic [LEN_W-1:0] len_q;

  logic             run;
  logic [CW-1:0]    k;
  logic             mrg_seg_valid, mrg_opsize, mrg_lock;
  logic [2:0]       mrg_seg;
  logic [1:0]       mrg_rep;
  logic [SUM_W-1:0] len_sum;
  logic [LEN_W-1:0] len_sat;
  logic             over, full_win, accept;

  // Leading-prefix count and merge onto the accumulators; newer lanes win.
  always_comb begin
    run           = 1'b1;
    k             = '0;
    mrg_seg_valid = seg_valid_q;
    mrg_seg       = seg_q;
    mrg_opsize    = opsize_q;
    mrg_lock      = lock_q;
    mrg_rep       = rep_q;
    for (int unsigned i = 0; i < W; i++) begin
      run = run & lane_prefix[i];
      if (run) begin
        k = k + CW'(1);
        if (lane_is_seg[i]) begin
          mrg_seg_valid = 1'b1;
          mrg_seg       = lane_seg[i];
        end
        if (lane_is_rep[i]) mrg_rep = lane_rep[i];
        mrg_opsize = mrg_opsize | lane_opsize[i];
        mrg_lock   = mrg_lock | lane_lock[i];
      end
    end
  end

  always_comb begin
    len_sum  = {1'b0, len_q} + SUM_W'(k);
    len_sat  = (len_sum > {1'b0, LEN_MAX}) ? LEN_MAX : len_sum[LEN_W-1:0];
    over     = (len_sum > SUM_W'(MAX_PREFIX));
    full_win = (k == CW'(W));
  end

  assign in_ready   = (state_q == ST_SCAN);
  assign accept     = in_valid & in_ready;
  assign in_consume = accept ? k : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      valid_q     <= 1'b0;
      seg_valid_q <= 1'b0;
      seg_q       <= SEG_ES;
      opsize_q    <= 1'b0;
      lock_q      <= 1'b0;
      rep_q       <= REP_NONE;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_SCAN;
      valid_q     <= 1'b0;
      seg_valid_q <= 1'b0;
      seg_q       <= SEG_ES;
      opsize_q    <= 1'b0;
      lock_q      <= 1'b0;
      rep_q       <= REP_NONE;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (accept) begin
            seg_valid_q <= mrg_seg_valid;
            seg_q       <= mrg_seg;
            opsize_q    <= mrg_opsize;
            lock_q      <= mrg_lock;
            rep_q       <= mrg_rep;
            len_q       <= len_sat;
            // A run ends on a short window or when it overruns the limit.
            if (!full_win || over) begin
              err_q   <= over;
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_SCAN;
            valid_q     <= 1'b0;
            seg_valid_q <= 1'b0;
            seg_q       <= SEG_ES;
            opsize_q    <= 1'b0;
            lock_q      <= 1'b0;
            rep_q       <= REP_NONE;
            len_q       <= '0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign out_valid     = valid_q;
  assign out_seg_valid = seg_valid_q;
  assign out_seg       = seg_q;
  assign out_opsize    = opsize_q;
  assign out_lock      = lock_q;
  assign out_rep       = rep_q;
  assign out_len       = len_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_prefix_scan_unit.sv
// Scoreboard bench for prefix_scan_unit: random and directed instructions
// against an instruction-level prefix model.
module tb_prefix_scan_unit;

  localparam int unsigned W    = 3;
  localparam int unsigned MAXP = 4;
  localparam int unsigned CW   = $clog2(W + 1);

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic       seg_valid;
    logic [2:0] seg;
    logic       opsize;
    logic       lock;
    logic [1:0] rep;
    logic [3:0] len;
    logic       err;
  } rec_t;

  logic           clk = 1'b0;
  logic           reset, flush, in_valid, in_ready, out_valid;
  logic           out_ready = 1'b0;
  logic [8*W-1:0] in_bytes;
  logic [CW-1:0]  in_consume;
  logic           out_seg_valid, out_opsize, out_lock, out_err;
  logic [2:0]     out_seg;
  logic [1:0]     out_rep;
  logic [3:0]     out_len;

  int   checks = 0;
  int   errors = 0;
  bit   hold_mode = 1'b0;
  rec_t exp_q [$];
  logic [7:0] pfx_tab [10] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64,
                               8'h65, 8'h66, 8'hF0, 8'hF2, 8'hF3};

  prefix_scan_unit #(.W(W), .MAX_PREFIX(MAXP)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_bytes      (in_bytes),
    .in_ready      (in_ready),
    .in_consume    (in_consume),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_seg_valid (out_seg_valid),
    .out_seg       (out_seg),
    .out_opsize    (out_opsize),
    .out_lock      (out_lock),
    .out_rep       (out_rep),
    .out_len       (out_len),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = hold_mode ? 1'b0 : ($urandom_range(0, 9) < 7);
  end

  function automatic bit is_pfx(input logic [7:0] b);
    foreach (pfx_tab[i]) if (pfx_tab[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] rand_nonprefix();
    logic [7:0] b;
    do b = 8'($urandom); while (is_pfx(b));
    return b;
  endfunction

  // Record implied by the first cnt prefix bytes of an instruction.
  function automatic rec_t model_rec(input byte_q_t p, input int cnt, input int total);
    rec_t r = '0;
    for (int i = 0; i < cnt; i++) begin
      case (p[i])
        8'h26: begin r.seg_valid = 1'b1; r.seg = 3'd0; end
        8'h2E: begin r.seg_valid = 1'b1; r.seg = 3'd1; end
        8'h36: begin r.seg_valid = 1'b1; r.seg = 3'd2; end
        8'h3E: begin r.seg_valid = 1'b1; r.seg = 3'd3; end
        8'h64: begin r.seg_valid = 1'b1; r.seg = 3'd4; end
        8'h65: begin r.seg_valid = 1'b1; r.seg = 3'd5; end
        8'h66: r.opsize = 1'b1;
        8'hF0: r.lock = 1'b1;
        8'hF2: r.rep = 2'b10;
        8'hF3: r.rep = 2'b11;
        default: ;
      endcase
    end
    r.len = (total > 15) ? 4'd15 : 4'(total);
    r.err = (total > int'(MAXP));
    return r;
  endfunction

  function automatic rec_t cur_rec();
    return {out_seg_valid, out_seg, out_opsize, out_lock, out_rep, out_len, out_err};
  endfunction

  task automatic do_step(input logic [8*W-1:0] win, input int exp_k);
    int waited = 0;
    in_valid = 1'b1;
    in_bytes = win;
    #1;
    while (in_ready !== 1'b1 && waited < 200) begin
      checks++;
      if (in_consume !== '0) begin
        errors++;
        $display("FAIL consume_not_ready act=%0d req=0", in_consume);
      end
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_timeout act=%b req=1", in_ready);
    end else if (in_consume !== CW'(exp_k)) begin
      errors++;
      $display("FAIL consume act=%0d req=%0d", in_consume, exp_k);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_instr(input byte_q_t p, input logic [7:0] opc, input bit push);
    int n = p.size();
    int pos = 0;
    int total = 0;
    int k;
    int ks [$];
    logic [8*W-1:0] win;
    do begin
      k = (n - pos >= int'(W)) ? int'(W) : n - pos;
      ks.push_back(k);
      pos += k;
      total += k;
    end while (k == int'(W) && total <= int'(MAXP));
    if (push) exp_q.push_back(model_rec(p, pos, total));
    pos = 0;
    foreach (ks[s]) begin
      for (int j = 0; j < int'(W); j++) begin
        int idx = pos + j;
        if (idx < n)       win[8*j +: 8] = p[idx];
        else if (idx == n) win[8*j +: 8] = opc;
        else               win[8*j +: 8] = 8'($urandom);
      end
      do_step(win, ks[s]);
      pos += ks[s];
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d out_valid=%b req=0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    byte_q_t p;
    rec_t    exp_r;
    int      n;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bytes = '0;

    fork
      forever begin
        @(negedge clk);
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rec_unexpected act=%h req=none", cur_rec());
          end else begin
            rec_t e;
            e = exp_q.pop_front();
            if (cur_rec() !== e) begin
              errors++;
              $display("FAIL rec act=%h req=%h", cur_rec(), e);
            end
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_hold act=%b req=0", in_ready);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur_rec() !== rec_t'(0)) begin
      errors++;
      $display("FAIL reset_state act=%b/%b/%h req=0/1/0", out_valid, in_ready, cur_rec());
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    p = {8'h66, 8'h2E};               run_instr(p, 8'h8B, 1'b1);
    p = {8'hF3};                      run_instr(p, 8'hA4, 1'b1);
    p = {};                           run_instr(p, 8'h90, 1'b1);
    p = {8'hF0, 8'h26, 8'h66, 8'h65}; run_instr(p, 8'h8B, 1'b1);
    p = {8'h66, 8'h66, 8'h66, 8'h66, 8'h66}; run_instr(p, 8'h0F, 1'b1);
    p = {8'h66, 8'h66, 8'h66};        run_instr(p, 8'h90, 1'b1);

    for (int t = 0; t < 250; t++) begin
      p = {};
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) p.push_back(pfx_tab[$urandom_range(0, 9)]);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_bytes = {W{8'h66}};
        #1;
        checks++;
        if (in_consume !== '0) begin
          errors++;
          $display("FAIL consume_idle act=%0d req=0", in_consume);
        end
        @(posedge clk); #1;
      end
      run_instr(p, rand_nonprefix(), 1'b1);
    end
    drain();

    // Held record must stay put until a flush clears it.
    hold_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    p = {8'h66};
    run_instr(p, 8'h8B, 1'b0);
    exp_r = model_rec(p, 1, 1);
    repeat (5) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cur_rec() !== exp_r) begin
        errors++;
        $display("FAIL hold act=%b/%b/%h req=1/0/%h", out_valid, in_ready, cur_rec(), exp_r);
      end
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush act=%b/%b req=0/1", out_valid, in_ready);
    end
    hold_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a prefix run discards it.
    in_valid = 1'b1;
    in_bytes = {8'hF2, 8'hF2, 8'hF2};
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur_rec() !== rec_t'(0)) begin
      errors++;
      $display("FAIL async_reset act=%b/%b/%h req=0/1/0", out_valid, in_ready, cur_rec());
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    p = {8'h66};
    run_instr(p, 8'h8B, 1'b1);
    p = {8'h3E, 8'hF2};
    run_instr(p, 8'hAE, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_scan_unit.md
# prefix_scan_unit

Sequential, parametrised x86 prefix scanner in the decode front end, between the instruction byte queue and opcode decode. Each cycle it examines a window of `W` instruction bytes and counts the leading prefix bytes. When a prefix run spans windows it accumulates across them. It then delivers one registered prefix record per instruction over a valid/ready handshake. Unlike the fixed 3-byte combinational size/segment map, it handles lock and rep prefixes, enforces a prefix limit and supports flush.

## Interface
- `W`, 3: bytes examined per cycle, range 1..8.
- `MAX_PREFIX`, 4: maximum legal prefix bytes per instruction, range 1..14.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  `in_bytes` holds valid bytes.
- `in_bytes`  in  8*W  instruction window; byte 0 at [7:0] is the oldest.
- `in_ready`  out  1  scanner accepts the window this cycle.
- `in_consume`  out  clog2(W+1)  bytes the queue must shift out when `in_valid & in_ready`.
- `out_valid`  out  1  prefix record valid.
- `out_ready`  in  1  downstream takes the record.
- `out_seg_valid`  out  1  a segment override is present.
- `out_seg`  out  3  segment: ES=0, CS=1, SS=2, DS=3, FS=4, GS=5.
- `out_opsize`  out  1  0x66 seen.
- `out_lock`  out  1  0xF0 seen.
- `out_rep`  out  2  00 none, 10 REPNE (F2), 11 REP (F3).
- `out_len`  out  4  prefix byte count, saturating at 15.
- `out_err`  out  1  prefix count exceeded `MAX_PREFIX`.

## Operation
- Prefix bytes are 26, 2E, 36, 3E, 64, 65, 66, F0, F2 and F3. Every other byte terminates the run.
- `k` is the number of leading prefix bytes in the window, 0..W.
- Merge rules within and across windows, oldest to newest:
  - Segment and rep are last-wins.
  - Opsize and lock are sticky OR.
  - Repeated identical prefixes count toward the length.
- States: SCAN and HOLD.
- SCAN: `in_ready=1`.
  - On accept with `k==W` and running total ≤ `MAX_PREFIX`: accumulate, `in_consume=W`, stay in SCAN.
  - On accept with `k<W`: merge the k prefixes, `in_consume=k`, register the record, go to HOLD.
  - On accept where the running total exceeds `MAX_PREFIX`: `out_err=1`, consume only the prefix bytes of this window, register the record, go to HOLD.
- HOLD: `in_ready=0`, `in_consume=0`, `out_valid=1`. When `out_ready=1`, clear the accumulators and return to SCAN.
- `k==0` in SCAN yields a record with `out_len=0` and all flags 0. Every instruction gets exactly one record.
- `in_consume` is combinational from `in_bytes` and state. It is 0 whenever `in_valid=0`.
- `flush`: next state SCAN, accumulators cleared, `out_valid` drops next cycle. `flush` overrides an accept or an output handshake in the same cycle.
- Reset values: state SCAN, `out_valid=0`, and all record fields 0.

## Timing
- Record latency: `out_valid` rises one cycle after the terminating window is accepted.
- Throughput:
  - One instruction per 2 cycles (accept, then hold).
  - Runs longer than `W` add one cycle per extra full window.
- Record outputs are registered and stable while `out_valid & !out_ready`.
- `in_ready` depends only on state. `in_consume` depends on state, `in_valid` and `in_bytes`.
- Asserting `reset` mid-run discards any partial accumulation. No record is emitted.

## Structure
- Shared package `prefix_pkg`:
  - Prefix byte constants.
  - Segment encodings.
  - Rep encodings.
  - State encoding.
  - Function for count width.
- Sub-module `prefix_byte_classify`: combinational, one instance per byte lane. Outputs `is_prefix`, `is_seg`, `seg[2:0]`, `is_opsize`, `is_lock`, `is_rep` and `rep[1:0]`.
- Top level contains:
  - Leading-prefix count `k`.
  - Lane merge with priority to the newest byte.
  - Accumulator registers.
  - FSM.
  - Saturating 4-bit length adder.

## Test plan
- W=3, bytes {66, 2E, 8B}, `out_ready=1` → `in_consume=2`; next cycle record opsize=1, seg=CS, len=2, err=0.
- W=3, bytes {F3, A4, ...} → rep=11, len=1. Then {90, ...} → len=0 and all flags 0.
- W=3, MAX_PREFIX=4, windows {F0, 26, 66} then {65, 8B, ...} → two accepts. Record has lock=1, opsize=1, seg=GS (last wins), len=4, err=0.
- W=3, MAX_PREFIX=4, windows {66, 66, 66} then {66, 66, 0F} → record len=5, err=1, `in_consume` of 3 then 2.
- Record held with `out_ready=0` for 5 cycles → outputs stable and `in_ready=0`. Then `flush=1` → `out_valid=0` next cycle and state SCAN.
- `reset` asserted low mid-accumulation after {F2, F2, F2} → all outputs 0 immediately. The first record after release is from fresh bytes only.
